otter_int_ctrl: RTL and testbench
=================================

Name: otter_int_ctrl

Overview:
- Interrupt/trap sequencer for the OTTER multicycle core, on the requesting side of the CSR trap interface.
- Synchronises and edge-detects external interrupt lines, holds per-source pending bits, and arbitrates by fixed priority.
- Handshakes with the multicycle control FSM at instruction boundaries.
- Drives the CSR's intTaken/intRet pulses and the PC redirect target, taken from mtvec on a trap and mepc on mret.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..16).
- SYNC_STAGES, 2, synchroniser depth per irq line (>=2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_SRC  raw async interrupt lines; rising edge = event
- mie  in  1  global interrupt enable from CSR
- mstatus  in  1  interrupt-active-enable bit from CSR
- mtvec  in  32  trap handler address from CSR
- mepc  in  32  return address from CSR
- int_ack  in  1  control FSM at instruction boundary, accepts the trap
- mret_exec  in  1  1-cycle pulse: control FSM executing mret
- int_req  out  1  trap request to control FSM
- int_taken  out  1  1-cycle pulse to CSR intTaken
- int_ret  out  1  1-cycle pulse to CSR intRet
- redirect_valid  out  1  1-cycle pulse: load PC with redirect_pc
- redirect_pc  out  32  new PC value
- int_cause  out  $clog2(NUM_SRC) (min 1)  index of the last taken source
- pending  out  NUM_SRC  current pending bits (debug/readback)

Behaviour:
- Reset (async, rst_n=0): all outputs are 0, synchroniser flops are 0, pending=0, state IDLE.
  - Reset mid-operation aborts the pending trap or mret.
  - No pulse is emitted on release of reset.
- Sync/edge detect:
  - Each line passes through SYNC_STAGES flops plus one history flop.
  - A rising edge sets pending[i] at the next clock.
  - A raw rise ahead of edge k sets pending at edge k+SYNC_STAGES.
  - Held-high lines do not re-trigger; the line must fall and rise again.
- Pending clear: pending[i] clears only in TAKE for i==int_cause.
  - A new edge on the same source in the same cycle wins, so the bit stays set.
- Eligible = |pending & mie & mstatus.
- Arbitration: lowest index wins. The winner is latched into int_cause on the IDLE->REQ transition and is frozen until the next REQ.
- All outputs are registered. Pulses last exactly one cycle.
- FSM states: IDLE, REQ, TAKE, RET, SETTLE.
  - IDLE:
    - mret_exec -> RET.
    - Else if eligible -> REQ, with int_req=1 from the next cycle.
  - REQ, int_req held high:
    - mret_exec has priority -> RET; the request is withdrawn and pending is kept.
    - Else if int_ack -> TAKE.
    - Else if eligible drops (mie or mstatus cleared) -> IDLE, int_req=0.
    - int_cause does not change while in REQ, even if a higher-priority source arrives.
  - TAKE, one cycle: int_taken=1, redirect_valid=1, redirect_pc=mtvec, int_req=0, clear pending[int_cause] -> SETTLE.
  - RET, one cycle: int_ret=1, redirect_valid=1, redirect_pc=mepc -> SETTLE.
  - SETTLE, one cycle, no outputs -> IDLE. This lets the CSR update mstatus so a stale mstatus=1 cannot cause a double take.
- Handshake latency: int_ack sampled at edge t gives int_taken/redirect_valid high during cycle t+1.
- redirect_pc holds its last value when redirect_valid=0.
- int_ack while not in REQ is ignored.
- mret_exec in TAKE/RET/SETTLE is ignored. The control FSM guarantees mret cannot occur there.
- mtvec/mepc are sampled on the edge entering TAKE/RET.

Test Plan:
- Reset: rst_n=0 mid-REQ with irq_in=4'b0001 -> all outputs 0 immediately (async); after release with no new edge, int_req stays 0 and pending=0.
- Single trap: mie=1, mstatus=1, mtvec=0x0000_0100, rise irq_in[2] -> pending[2]=1 after 2 edges, int_req=1 one edge later; int_ack pulse -> next cycle int_taken=1, redirect_valid=1, redirect_pc=0x100, int_cause=2; the following cycle pending[2]=0 and int_req=0.
- Priority/masking:
  - Rise irq_in[3] and irq_in[1] in the same cycle -> int_cause=1 on the first take.
  - With mstatus=0 -> int_req stays 0 while pending=4'b1010.
  - Set mstatus=1 -> REQ with cause 1, then after a second take cause 3.
- Withdraw: in REQ, drop mie before int_ack -> int_req=0 next cycle, no int_taken, pending unchanged.
- mret: mepc=0x0000_2004, pulse mret_exec in IDLE -> next cycle int_ret=1, redirect_valid=1, redirect_pc=0x2004; then one SETTLE cycle.
  - mret_exec and int_ack in the same REQ cycle -> RET taken, no int_taken.
- No double-take: hold int_ack=1 continuously across TAKE/SETTLE with CSR model clearing mstatus -> exactly one int_taken pulse per edge on irq_in[0]; holding irq_in[0] high produces no second trap.

Source files
------------

// File: rtl/otter_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : otter_int_ctrl
// Description : Interrupt/trap sequencer for the OTTER multicycle core.
//               Synchronises and edge-detects external interrupt lines,
//               keeps per-source pending bits, picks the lowest-index
//               pending source, handshakes with the control FSM at
//               instruction boundaries and drives the CSR intTaken/intRet
//               pulses plus the PC redirect (mtvec on trap, mepc on mret).
// Ports       : clk, rst_n          - clock, async active-low reset
//               irq_in[NUM_SRC]     - raw async interrupt lines (rise = event)
//               mie, mstatus        - global / interrupt-active enables
//               mtvec, mepc         - trap handler / return addresses
//               int_ack, mret_exec  - control FSM trap accept / mret pulse
//               int_req             - trap request to control FSM
//               int_taken, int_ret  - 1-cycle pulses to CSR
//               redirect_valid/pc   - 1-cycle PC load strobe and target
//               int_cause           - index of last taken source
//               pending             - pending bits (readback)
// Revision    : 1.0 - initial release
// ============================================================================
module otter_int_ctrl #(
   parameter int NUM_SRC     = 4,
   parameter int SYNC_STAGES = 2,
   localparam int C_CAUSE_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_SRC-1:0]   irq_in,
   input  logic                 mie,
   input  logic                 mstatus,
   input  logic [31:0]          mtvec,
   input  logic [31:0]          mepc,
   input  logic                 int_ack,
   input  logic                 mret_exec,
   output logic                 int_req,
   output logic                 int_taken,
   output logic                 int_ret,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic [C_CAUSE_W-1:0] int_cause,
   output logic [NUM_SRC-1:0]   pending
);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_req    = 3'd1;
   localparam logic [2:0] c_st_take   = 3'd2;
   localparam logic [2:0] c_st_ret    = 3'd3;
   localparam logic [2:0] c_st_settle = 3'd4;

   // r_sync[0] is the first (metastable-capture) stage.
   logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
   logic [NUM_SRC-1:0]   r_hist;
   logic [NUM_SRC-1:0]   r_pending;
   logic [NUM_SRC-1:0]   w_rise;
   logic [NUM_SRC-1:0]   w_clr;
   logic [NUM_SRC-1:0]   w_pending_nxt;
   logic [C_CAUSE_W-1:0] r_cause;
   logic [C_CAUSE_W-1:0] w_winner;
   logic                 w_eligible;
   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;

   logic                 r_int_req, r_int_taken, r_int_ret, r_redirect_valid;
   logic [31:0]          r_redirect_pc;
   logic                 w_int_req_nxt, w_int_taken_nxt, w_int_ret_nxt;
   logic                 w_redirect_valid_nxt;
   logic [31:0]          w_redirect_pc_nxt;

   // ------------------------------------------------------------------
   // Synchroniser chain plus one history flop for edge detection
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

   // ------------------------------------------------------------------
   // Pending bits: cleared only for the source being taken; a fresh edge
   // on that same source in the same cycle keeps the bit set.
   // ------------------------------------------------------------------
   always_comb begin
      w_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_clr[i] = (r_state == c_st_take) && (r_cause == C_CAUSE_W'(i));
      end
      w_pending_nxt = (r_pending & ~w_clr) | w_rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign w_eligible = (|r_pending) & mie & mstatus;

   // Lowest index wins: scan downward so the last assignment is the lowest.
   always_comb begin
      w_winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_winner = C_CAUSE_W'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_cause <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Cause is frozen for the whole request; only a new IDLE->REQ
         // transition re-arbitrates.
         if ((r_state == c_st_idle) && (w_state_nxt == c_st_req)) begin
            r_cause <= w_winner;
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (mret_exec) begin
               w_state_nxt = c_st_ret;
            end else if (w_eligible) begin
               w_state_nxt = c_st_req;
            end
         end
         c_st_req: begin
            if (mret_exec) begin
               w_state_nxt = c_st_ret;
            end else if (int_ack) begin
               w_state_nxt = c_st_take;
            end else if (!w_eligible) begin
               w_state_nxt = c_st_idle;
            end
         end
         c_st_take:   w_state_nxt = c_st_settle;
         c_st_ret:    w_state_nxt = c_st_settle;
         // SETTLE gives the CSR one cycle to update mstatus before the
         // next eligibility decision.
         c_st_settle: w_state_nxt = c_st_idle;
         default:     w_state_nxt = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic, decoded from the next state so that every output
   // is registered yet aligned with the state it belongs to.
   // ------------------------------------------------------------------
   always_comb begin
      w_int_req_nxt        = (w_state_nxt == c_st_req);
      w_int_taken_nxt      = (w_state_nxt == c_st_take);
      w_int_ret_nxt        = (w_state_nxt == c_st_ret);
      w_redirect_valid_nxt = w_int_taken_nxt | w_int_ret_nxt;
      w_redirect_pc_nxt    = r_redirect_pc;
      if (w_int_taken_nxt) begin
         w_redirect_pc_nxt = mtvec;
      end else if (w_int_ret_nxt) begin
         w_redirect_pc_nxt = mepc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_int_req        <= 1'b0;
         r_int_taken      <= 1'b0;
         r_int_ret        <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_int_req        <= w_int_req_nxt;
         r_int_taken      <= w_int_taken_nxt;
         r_int_ret        <= w_int_ret_nxt;
         r_redirect_valid <= w_redirect_valid_nxt;
         r_redirect_pc    <= w_redirect_pc_nxt;
      end
   end

   assign int_req        = r_int_req;
   assign int_taken      = r_int_taken;
   assign int_ret        = r_int_ret;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign int_cause      = r_cause;
   assign pending        = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_otter_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_int_ctrl
// Description : Self-checking bench for otter_int_ctrl. Directed scenarios
//               plus a randomized run against a cycle-level reference model
//               built from the documented interrupt rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_int_ctrl;

   localparam int NUM_SRC     = 4;
   localparam int SYNC_STAGES = 2;
   localparam int P_IDLE = 0, P_REQ = 1, P_TAKE = 2, P_RET = 3, P_SETTLE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  irq_in = '0;
   logic        mie = 1'b0, mstatus = 1'b0;
   logic [31:0] mtvec = '0, mepc = '0;
   logic        int_ack = 1'b0, mret_exec = 1'b0;
   logic        int_req, int_taken, int_ret, redirect_valid;
   logic [31:0] redirect_pc;
   logic [1:0]  int_cause;
   logic [3:0]  pending;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [3:0]  hist[$];   // hist[0] = irq_in sampled at the most recent edge
   int          m_phase;
   logic [3:0]  m_pend;
   int          m_cause;
   bit          m_req, m_taken, m_ret, m_rv;
   logic [31:0] m_pc;

   otter_int_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mie(mie), .mstatus(mstatus),
      .mtvec(mtvec), .mepc(mepc), .int_ack(int_ack), .mret_exec(mret_exec),
      .int_req(int_req), .int_taken(int_taken), .int_ret(int_ret),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .int_cause(int_cause), .pending(pending)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int lowest_set(input logic [3:0] p);
      for (int i = 0; i < 4; i++) if (p[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      hist = {};
      for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back(4'b0000);
      m_phase = P_IDLE; m_pend = '0; m_cause = 0;
      m_req = 0; m_taken = 0; m_ret = 0; m_rv = 0; m_pc = '0;
   endtask

   // One clock edge of the interrupt rules: a raw rise seen SYNC_STAGES
   // edges ago (and low the edge before) becomes pending now.
   task automatic model_step();
      logic [3:0] rise;
      bit         elig;
      int         nxt;
      if (!rst_n) begin
         model_reset();
         return;
      end
      rise = hist[SYNC_STAGES-1] & ~hist[SYNC_STAGES];
      hist.push_front(irq_in);
      void'(hist.pop_back());
      elig = (m_pend != 0) && mie && mstatus;
      nxt  = m_phase;
      case (m_phase)
         P_IDLE: begin
            if (mret_exec) nxt = P_RET;
            else if (elig) begin nxt = P_REQ; m_cause = lowest_set(m_pend); end
         end
         P_REQ: begin
            if (mret_exec) nxt = P_RET;
            else if (int_ack) nxt = P_TAKE;
            else if (!elig) nxt = P_IDLE;
         end
         P_TAKE: begin m_pend[m_cause] = 1'b0; nxt = P_SETTLE; end
         P_RET:  nxt = P_SETTLE;
         default: nxt = P_IDLE;
      endcase
      m_pend  = m_pend | rise;
      m_req   = (nxt == P_REQ);
      m_taken = (nxt == P_TAKE);
      m_ret   = (nxt == P_RET);
      m_rv    = m_taken | m_ret;
      if (m_taken) m_pc = mtvec;
      if (m_ret)   m_pc = mepc;
      m_phase = nxt;
   endtask

   // Advance one clock; returns 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      checks++;
      if ({int_req, int_taken, int_ret, redirect_valid, redirect_pc, int_cause, pending} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b tk=%b rt=%b rv=%b pc=%h cause=%0d pend=%b, want all 0",
                  int_req, int_taken, int_ret, redirect_valid, redirect_pc, int_cause, pending);
      end
      cycle(); cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      checks++;
      if ({int_req, int_taken, int_ret, redirect_valid, pending} !== '0) begin
         errors++;
         $display("FAIL reset_release: got req=%b tk=%b rt=%b rv=%b pend=%b, want all 0",
                  int_req, int_taken, int_ret, redirect_valid, pending);
      end
   endtask

   task automatic test_single_trap();
      mtvec = 32'h0000_0100; mie = 1; mstatus = 1;
      irq_in = 4'b0100;
      cycle();          // raw rise ahead of this edge
      cycle();
      checks++;
      if (pending !== 4'b0000) begin
         errors++; $display("FAIL single_early_pend: got %b want 0000", pending);
      end
      cycle();          // edge k+SYNC_STAGES
      checks++;
      if (pending !== 4'b0100 || int_req !== 1'b0) begin
         errors++; $display("FAIL single_pend: got pend=%b req=%b want 0100/0", pending, int_req);
      end
      cycle();
      checks++;
      if (int_req !== 1'b1 || int_cause !== 2'd2) begin
         errors++; $display("FAIL single_req: got req=%b cause=%0d want 1/2", int_req, int_cause);
      end
      int_ack = 1;
      cycle();
      int_ack = 0;
      checks++;
      if (int_taken !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h100 ||
          int_cause !== 2'd2 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL single_take: got tk=%b rv=%b pc=%h cause=%0d req=%b want 1/1/100/2/0",
                  int_taken, redirect_valid, redirect_pc, int_cause, int_req);
      end
      cycle();
      checks++;
      if (pending !== 4'b0000 || int_req !== 1'b0 || int_taken !== 1'b0 ||
          redirect_valid !== 1'b0 || redirect_pc !== 32'h100) begin
         errors++;
         $display("FAIL single_after: got pend=%b req=%b tk=%b rv=%b pc=%h want 0000/0/0/0/100",
                  pending, int_req, int_taken, redirect_valid, redirect_pc);
      end
      irq_in = 4'b0000;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   task automatic test_priority();
      mstatus = 0; mie = 1;
      irq_in = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (int_req !== 1'b0) begin
            errors++; $display("FAIL prio_masked_req: cyc=%0d got %b want 0", i, int_req);
         end
      end
      checks++;
      if (pending !== 4'b1010) begin
         errors++; $display("FAIL prio_pend: got %b want 1010", pending);
      end
      mstatus = 1;
      cycle();
      checks++;
      if (int_req !== 1'b1 || int_cause !== 2'd1) begin
         errors++; $display("FAIL prio_first_req: got req=%b cause=%0d want 1/1", int_req, int_cause);
      end
      int_ack = 1;
      cycle();
      int_ack = 0;
      checks++;
      if (int_taken !== 1'b1 || int_cause !== 2'd1) begin
         errors++; $display("FAIL prio_first_take: got tk=%b cause=%0d want 1/1", int_taken, int_cause);
      end
      cycle();
      checks++;
      if (pending !== 4'b1000) begin
         errors++; $display("FAIL prio_pend_after1: got %b want 1000", pending);
      end
      for (int n = 0; n < 6 && !int_req; n++) cycle();
      checks++;
      if (int_req !== 1'b1 || int_cause !== 2'd3) begin
         errors++; $display("FAIL prio_second_req: got req=%b cause=%0d want 1/3", int_req, int_cause);
      end
      int_ack = 1;
      cycle();
      int_ack = 0;
      checks++;
      if (int_taken !== 1'b1 || int_cause !== 2'd3) begin
         errors++; $display("FAIL prio_second_take: got tk=%b cause=%0d want 1/3", int_taken, int_cause);
      end
      cycle();
      checks++;
      if (pending !== 4'b0000) begin
         errors++; $display("FAIL prio_pend_after2: got %b want 0000", pending);
      end
      irq_in = 4'b0000;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   task automatic test_withdraw();
      int taken_seen;
      irq_in = 4'b0001;
      for (int n = 0; n < 8 && !int_req; n++) cycle();
      checks++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL withdraw_wait_req: got %b want 1", int_req);
      end
      mie = 0;
      cycle();
      checks++;
      if (int_req !== 1'b0 || int_taken !== 1'b0 || pending !== 4'b0001) begin
         errors++; $display("FAIL withdraw: got req=%b tk=%b pend=%b want 0/0/0001",
                            int_req, int_taken, pending);
      end
      taken_seen = 0;
      int_ack = 1;   // ignored outside REQ
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (int_taken) taken_seen++;
      end
      int_ack = 0;
      checks++;
      if (taken_seen != 0) begin
         errors++; $display("FAIL withdraw_no_take: got %0d takes want 0", taken_seen);
      end
      mie = 1;
      for (int n = 0; n < 6 && !int_req; n++) cycle();
      int_ack = 1;
      cycle();
      int_ack = 0;
      checks++;
      if (int_taken !== 1'b1 || int_cause !== 2'd0) begin
         errors++; $display("FAIL withdraw_retake: got tk=%b cause=%0d want 1/0", int_taken, int_cause);
      end
      irq_in = 4'b0000;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   task automatic test_mret();
      mepc = 32'h0000_2004;
      mret_exec = 1;
      cycle();
      mret_exec = 0;
      checks++;
      if (int_ret !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h2004 || int_taken !== 1'b0) begin
         errors++; $display("FAIL mret_idle: got rt=%b rv=%b pc=%h tk=%b want 1/1/2004/0",
                            int_ret, redirect_valid, redirect_pc, int_taken);
      end
      cycle();
      checks++;
      if (int_ret !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h2004 || int_req !== 1'b0) begin
         errors++; $display("FAIL mret_settle: got rt=%b rv=%b pc=%h req=%b want 0/0/2004/0",
                            int_ret, redirect_valid, redirect_pc, int_req);
      end
      cycle();
      irq_in = 4'b0010;
      for (int n = 0; n < 8 && !int_req; n++) cycle();
      mret_exec = 1; int_ack = 1; mepc = 32'h0000_3008;
      cycle();
      mret_exec = 0; int_ack = 0;
      checks++;
      if (int_ret !== 1'b1 || int_taken !== 1'b0 || redirect_pc !== 32'h3008 || int_req !== 1'b0) begin
         errors++; $display("FAIL mret_vs_ack: got rt=%b tk=%b pc=%h req=%b want 1/0/3008/0",
                            int_ret, int_taken, redirect_pc, int_req);
      end
      cycle();
      checks++;
      if (pending !== 4'b0010) begin
         errors++; $display("FAIL mret_keeps_pend: got %b want 0010", pending);
      end
      for (int n = 0; n < 6 && !int_req; n++) cycle();
      int_ack = 1;
      cycle();
      int_ack = 0;
      checks++;
      if (int_taken !== 1'b1 || int_cause !== 2'd1) begin
         errors++; $display("FAIL mret_later_take: got tk=%b cause=%0d want 1/1", int_taken, int_cause);
      end
      irq_in = 4'b0000;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   task automatic test_no_double_take();
      int takes;
      for (int rep = 0; rep < 2; rep++) begin
         mie = 1; mstatus = 1; int_ack = 1;
         irq_in = 4'b0001;
         takes = 0;
         for (int i = 0; i < 30; i++) begin
            cycle();
            if (int_taken) begin
               takes++;
               mstatus = 0;          // CSR clears interrupt enable on trap entry
            end
            if (i == 15) mstatus = 1; // handler re-enables while line still high
         end
         checks++;
         if (takes != 1) begin
            errors++; $display("FAIL no_double_take rep=%0d: got %0d takes want 1", rep, takes);
         end
         irq_in = 4'b0000;
         int_ack = 0;
         for (int i = 0; i < 4; i++) cycle();
      end
   endtask

   task automatic test_async_reset();
      mie = 1; mstatus = 1;
      irq_in = 4'b0001;
      for (int n = 0; n < 8 && !int_req; n++) cycle();
      checks++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL areset_wait_req: got %b want 1", int_req);
      end
      #2;
      rst_n = 0;
      model_reset();
      #1;
      checks++;
      if ({int_req, int_taken, int_ret, redirect_valid, redirect_pc, int_cause, pending} !== '0) begin
         errors++;
         $display("FAIL areset_immediate: got req=%b pc=%h cause=%0d pend=%b want 0",
                  int_req, redirect_pc, int_cause, pending);
      end
      irq_in = 4'b0000;
      cycle(); cycle();
      rst_n = 1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks++;
         if (int_req !== 1'b0 || pending !== 4'b0000 || int_taken !== 1'b0) begin
            errors++; $display("FAIL areset_after: cyc=%0d got req=%b pend=%b tk=%b want 0",
                               i, int_req, pending, int_taken);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
         mie     = ($urandom_range(15) != 0);
         if ($urandom_range(9) == 0) mstatus = ~mstatus;
         int_ack = ($urandom_range(2) == 0);
         mret_exec = ((m_phase == P_IDLE) || (m_phase == P_REQ)) && ($urandom_range(15) == 0);
         mtvec   = $urandom;
         mepc    = $urandom;
         cycle();
         checks++;
         if ({int_req, int_taken, int_ret, redirect_valid} !== {m_req, m_taken, m_ret, m_rv}) begin
            errors++; $display("FAIL rand_ctrl cyc=%0d: got req/tk/rt/rv=%b want %b", c,
                               {int_req, int_taken, int_ret, redirect_valid}, {m_req, m_taken, m_ret, m_rv});
         end
         checks++;
         if (redirect_pc !== m_pc) begin
            errors++; $display("FAIL rand_pc cyc=%0d: got %h want %h", c, redirect_pc, m_pc);
         end
         checks++;
         if (pending !== m_pend) begin
            errors++; $display("FAIL rand_pend cyc=%0d: got %b want %b", c, pending, m_pend);
         end
         checks++;
         if (int_cause !== 2'(m_cause)) begin
            errors++; $display("FAIL rand_cause cyc=%0d: got %0d want %0d", c, int_cause, m_cause);
         end
      end
      mret_exec = 0; int_ack = 0;
   endtask

   initial begin
      test_reset();
      test_single_trap();
      test_priority();
      test_withdraw();
      test_mret();
      test_no_double_take();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
